// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: format codes, output buffer states
// and the RV32 instruction width.
package imm_pkg;

    localparam int INSTR_WIDTH = 32;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_B     = 3'b001,
        IMM_S     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_SHAMT = 3'b101
    } imm_src_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32 immediate decoder. Codes outside the six known formats
// give a zero immediate and raise illegal.
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [2:0]             imm_src,
    output logic [DATA_WIDTH-1:0]  imm,
    output logic                   illegal
);

    logic [31:0] imm32;
    logic        unused_opcode;

    // Opcode bits never contribute to an immediate.
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (imm_src_t'(imm_src))
            IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_B:     imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_U:     imm32 = {instr[31:12], 12'b0};
            IMM_J:     imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm32 = {27'b0, instr[24:20]};
            default:   illegal = 1'b1;
        endcase
    end

    // Bit 31 of the 32-bit form is already the correct fill bit for every
    // format (zero for SHAMT and illegal codes), so widening is uniform.
    always_comb begin
        imm        = {DATA_WIDTH{imm32[31]}};
        imm[31:0]  = imm32;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a registered 2-entry skid buffer on the output so
// in_ready never depends combinationally on out_ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [2:0]             in_imm_src,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_imm,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   out_illegal
);

    logic [DATA_WIDTH-1:0] dec_imm;
    logic                  dec_illegal;

    buf_state_t            state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic [DATA_WIDTH-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic [TAG_WIDTH-1:0]  main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic                  main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
    logic                  in_fire, out_fire;

    imm_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign out_valid   = (state_q != BUF_EMPTY);
    assign in_ready    = in_ready_q;
    assign out_imm     = main_imm_q;
    assign out_tag     = main_tag_q;
    assign out_illegal = main_ill_q;
    assign in_fire     = in_valid & in_ready_q;
    assign out_fire    = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        main_ill_d = main_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: if (in_fire) begin
                    main_imm_d = dec_imm;
                    main_tag_d = in_tag;
                    main_ill_d = dec_illegal;
                    state_d    = BUF_ONE;
                end
                BUF_ONE: case ({in_fire, out_fire})
                    2'b10: begin
                        skid_imm_d = dec_imm;
                        skid_tag_d = in_tag;
                        skid_ill_d = dec_illegal;
                        state_d    = BUF_FULL;
                    end
                    2'b01: state_d = BUF_EMPTY;
                    2'b11: begin
                        main_imm_d = dec_imm;
                        main_tag_d = in_tag;
                        main_ill_d = dec_illegal;
                    end
                    default: ;
                endcase
                // in_ready is low while full, so only the drain can happen here.
                BUF_FULL: if (out_fire) begin
                    main_imm_d = skid_imm_q;
                    main_tag_d = skid_tag_q;
                    main_ill_d = skid_ill_q;
                    state_d    = BUF_ONE;
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
        in_ready_d = (state_d != BUF_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
            main_imm_q <= '0;
            main_tag_q <= '0;
            main_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_imm_q <= main_imm_d;
            main_tag_q <= main_tag_d;
            main_ill_q <= main_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: 32- and 64-bit instances share stimulus
// and are compared each cycle against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [4:0]  out_tag32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag64;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    logic model_ready;

    always #5 clk = ~clk;

    imm_gen_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_illegal32)
    );

    imm_gen_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s);
        longint v;
        case (s)
            3'd0:    v = longint'($signed(i[31:20]));
            3'd1:    v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'd2:    v = longint'($signed({i[31:25], i[11:7]}));
            3'd3:    v = longint'($signed({i[31:12], 12'h000}));
            3'd4:    v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3'd5:    v = longint'(i[24:20]);
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic check_outputs();
        chk("in_ready32", {63'd0, in_ready32}, {63'd0, model_ready});
        chk("in_ready64", {63'd0, in_ready64}, {63'd0, model_ready});
        chk("out_valid32", {63'd0, out_valid32}, {63'd0, q.size() > 0});
        chk("out_valid64", {63'd0, out_valid64}, {63'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("imm32", {32'd0, out_imm32}, {32'd0, q[0].imm[31:0]});
            chk("imm64", out_imm64, q[0].imm);
            chk("tag32", {59'd0, out_tag32}, {59'd0, q[0].tag});
            chk("tag64", {59'd0, out_tag64}, {59'd0, q[0].tag});
            chk("ill32", {63'd0, out_illegal32}, {63'd0, q[0].ill});
            chk("ill64", {63'd0, out_illegal64}, {63'd0, q[0].ill});
        end
    endtask

    // Drive one cycle of inputs (called at negedge), advance the model at the
    // edge, then check the outputs at the following negedge.
    task automatic step(input logic vld, input logic [31:0] instr, input logic [2:0] src,
                        input logic [4:0] tag, input logic ordy, input logic fl);
        bit   do_in, do_out;
        exp_t e;
        in_valid   = vld;
        in_instr   = instr;
        in_imm_src = src;
        in_tag     = tag;
        out_ready  = ordy;
        flush      = fl;
        do_in  = vld && model_ready;
        do_out = ordy && (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_out) void'(q.pop_front());
            if (do_in) begin
                e.imm = ref_imm(instr, src);
                e.tag = tag;
                e.ill = (src > 3'd5);
                q.push_back(e);
            end
        end
        model_ready = (q.size() < 2);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 3'd0, 5'd0, ordy, 1'b0);
    endtask

    initial begin
        logic [31:0] fmt_instr [4];
        logic [2:0]  fmt_src   [4];
        logic [31:0] fmt_exp   [4];

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_imm_src = '0; in_tag = '0; out_ready = 1'b0;
        model_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, out_valid32}, 64'd0);
        chk("rst_ready", {63'd0, in_ready32}, 64'd1);
        chk("rst_imm64", out_imm64, 64'd0);
        chk("rst_tag", {59'd0, out_tag32}, 64'd0);
        chk("rst_ill", {63'd0, out_illegal64}, 64'd0);
        rst_n = 1'b1;

        // Format check: I, S, B, U back to back.
        fmt_instr = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7};
        fmt_src   = '{3'd0, 3'd2, 3'd1, 3'd3};
        fmt_exp   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, fmt_instr[k], fmt_src[k], 5'(k), 1'b1, 1'b0);
            chk("fmt_imm", {32'd0, out_imm32}, {32'd0, fmt_exp[k]});
        end
        chk("fmt_u64", out_imm64, 64'h0000_0000_1234_5000);
        idle(1'b1);

        // Backpressure: two accepts with out_ready low, then drain.
        step(1'b1, 32'hFFF00093, 3'd0, 5'h03, 1'b0, 1'b0);
        step(1'b1, 32'h01F09093, 3'd5, 5'h04, 1'b0, 1'b0);
        chk("bp_ready0", {63'd0, in_ready32}, 64'd0);
        step(1'b1, 32'h12345678, 3'd0, 5'h05, 1'b0, 1'b0);
        chk("bp_hold", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
        chk("bp_second", {59'd0, out_tag32}, 64'h04);
        idle(1'b1);
        chk("bp_ready1", {63'd0, in_ready32}, 64'd1);

        // Illegal code and 64-bit sign extension.
        step(1'b1, 32'hDEADBEEF, 3'd7, 5'h1A, 1'b1, 1'b0);
        chk("ill_flag", {63'd0, out_illegal32}, 64'd1);
        chk("ill_imm", out_imm64, 64'd0);
        chk("ill_tag", {59'd0, out_tag32}, 64'h1A);
        step(1'b1, 32'hFFF00093, 3'd0, 5'h01, 1'b1, 1'b0);
        chk("w64_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1'b1);

        // Flush while full with a valid input presented.
        step(1'b1, 32'h00100093, 3'd0, 5'h06, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 3'd0, 5'h07, 1'b0, 1'b0);
        step(1'b1, 32'h7FF00093, 3'd0, 5'h1F, 1'b0, 1'b1);
        chk("fl_valid", {63'd0, out_valid32}, 64'd0);
        chk("fl_ready", {63'd0, in_ready32}, 64'd1);
        idle(1'b1);
        idle(1'b1);

        // Reset while full.
        step(1'b1, 32'h00100093, 3'd0, 5'h08, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 3'd0, 5'h09, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {63'd0, out_valid32}, 64'd0);
        chk("rst_mid_ready", {63'd0, in_ready64}, 64'd1);
        q.delete();
        model_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h01F09093, 3'd5, 5'h0B, 1'b1, 1'b0);
        chk("shamt_imm", {32'd0, out_imm32}, 64'h1F);
        idle(1'b1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                 5'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
        end
        repeat (3) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the output immediate width; legal values are 32 or greater.
REQ-002 The block SHALL have parameter TAG_WIDTH, default 5, giving the width of the sideband tag carried alongside each instruction.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream instruction is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept an instruction.
REQ-008 The block SHALL have port in_instr, input, 32 bits: the raw RV32 instruction word.
REQ-009 The block SHALL have port in_imm_src, input, 3 bits: the immediate format select.
REQ-010 The block SHALL have port in_tag, input, TAG_WIDTH bits: the sideband tag.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the output entry is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output entry.
REQ-013 The block SHALL have port out_imm, output, DATA_WIDTH bits: the extended immediate.
REQ-014 The block SHALL have port out_tag, output, TAG_WIDTH bits: the tag of the output entry.
REQ-015 The block SHALL have port out_illegal, output, 1 bit: the entry carried an unsupported imm_src.

Function
REQ-016 Decode SHALL use these imm_src codes:
- 000 I: sign-extend instr[31:20].
- 001 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- 010 S: sign-extend {instr[31:25], instr[11:7]}.
- 011 U: {instr[31:12], 12'b0}, sign-extended to DATA_WIDTH.
- 100 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- 101 SHAMT: zero-extend instr[24:20].
REQ-017 For codes 110 and 111, out_imm SHALL be 0 and out_illegal SHALL be 1; for all other codes out_illegal SHALL be 0.
REQ-018 Sign extension SHALL replicate instr[31] up to bit DATA_WIDTH-1 for any DATA_WIDTH of 32 or greater.
REQ-019 A transfer SHALL occur on a clock edge when in_valid and in_ready are both high; the decoded result SHALL be registered, so out_valid rises on the edge after acceptance (latency 1).
REQ-020 The output stage SHALL be a 2-entry skid buffer (main register plus skid register) with states EMPTY, ONE and FULL.
REQ-021 State transitions SHALL be:
- EMPTY to ONE on accept.
- ONE to FULL on accept without output transfer.
- ONE to EMPTY on output transfer without accept.
- ONE stays ONE on simultaneous accept and output transfer.
- FULL to ONE on output transfer; no accept is possible while FULL.
REQ-022 in_ready SHALL be a registered signal equal to (state != FULL), with no combinational path from out_ready.
REQ-023 Sustained throughput SHALL be one instruction per cycle while out_ready is held high.
REQ-024 Entries SHALL leave in acceptance order; when FULL drains, the skid entry moves to the main register on the same edge as the output transfer.
REQ-025 While out_valid is high and out_ready is low, out_imm, out_tag and out_illegal SHALL hold stable.
REQ-026 flush SHALL have priority over everything else: on the next edge the state becomes EMPTY, any input presented in the flush cycle is dropped, and out_valid falls.
REQ-027 The contents of the data registers are don't-care while out_valid is low.

Reset
REQ-028 While rst_n is low, the state SHALL be EMPTY, out_valid 0, in_ready 1, and out_imm, out_tag and out_illegal 0.
REQ-029 Reset asserted mid-transfer SHALL take effect immediately and discard all entries; the first accept is possible on the first edge after rst_n is released.

Structure
REQ-030 Package imm_pkg SHALL hold the imm_src_t enum (the six codes above), the buffer state enum and the constant INSTR_WIDTH = 32.
REQ-031 Decoding SHALL live in a combinational sub-module imm_decode (instr and imm_src in; imm and illegal out, parameterised by DATA_WIDTH); imm_gen_pipe instantiates it once at its input.

Verification
REQ-032 Format check: send I 0xFFF00093, S 0xFE20AE23, B 0xFE000CE3 and U 0x123450B7 back-to-back with out_ready=1 -> out_imm is 0xFFFFFFFF, 0xFFFFFFFC, 0xFFFFFFF8, 0x12345000 on four consecutive cycles.
REQ-033 Backpressure: out_ready=0 and two accepts -> in_ready goes 0 after the second accept and the first output is held stable; then out_ready=1 -> both entries emerge in order and in_ready returns to 1.
REQ-034 Illegal code and width: imm_src=111 with tag 5'h1A -> out_illegal=1, out_imm=0, out_tag=5'h1A; with DATA_WIDTH=64, I-type 0xFFF00093 -> out_imm = 64'hFFFF_FFFF_FFFF_FFFF.
REQ-035 Flush while FULL with in_valid=1 -> out_valid=0 on the next cycle, in_ready=1, and the dropped instruction never appears at the output.
REQ-036 Reset while FULL -> out_valid=0 and in_ready=1 immediately; after release, SHAMT instr 0x01F09093 -> out_imm=0x0000001F.
